// File: rtl/ddr_rsp_pkg.sv
// Shared types and constants for the DDR application-interface responder.
// Optional random backpressure is enabled with DDR_RSP_BACKPRESSURE_EN.
package ddr_rsp_pkg;

  localparam logic [2:0]  CMD_WRITE = 3'b000;
  localparam logic [2:0]  CMD_READ  = 3'b001;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic {S_CALIB, S_READY} rsp_state_e;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/ddr_rsp_wdf_fifo.sv
// 4-deep write-data FIFO; the caller never pushes when full or pops when empty.
module ddr_rsp_wdf_fifo #(
  parameter int W = 512
) (
  input  logic         ddr_ui_clk,
  input  logic         ddr_log_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [2:0]   count
);

  logic [W-1:0] slots [4];
  logic [1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge ddr_ui_clk) begin
    if (push) slots[wr_ptr_q] <= push_data;
  end

  assign head  = slots[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ddr_app_responder.sv
// Behavioural DDR app-interface responder: calibration delay, write-data FIFO,
// fixed-latency reads. Define DDR_RSP_BACKPRESSURE_EN for LFSR-driven backpressure.
module ddr_app_responder
  import ddr_rsp_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 28,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 200,
  parameter int RD_LATENCY   = 8
) (
  input  logic                    ddr_ui_clk,
  input  logic                    ddr_log_rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  input  logic [DATA_WIDTH*8-1:0] app_wdf_data,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_rdy,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH*8-1:0] app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    init_calib_complete,
  output logic [31:0]             wr_cnt,
  output logic [31:0]             rd_cnt,
  output logic                    err_cmd
);

  localparam int DW = DATA_WIDTH * 8;
  localparam int CW = $clog2(CALIB_CYCLES) + 1;

  rsp_state_e          state_q, state_d;
  logic [CW-1:0]       calib_cnt_q, calib_cnt_d;
  logic                calib_q, calib_d;
  logic                app_rdy_q, app_rdy_d, wdf_rdy_q, wdf_rdy_d;
  logic                pend_q, pend_d;
  logic [MEM_AW-1:0]   pend_idx_q, pend_idx_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                err_q, err_d;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [DW-1:0]       dat_pipe_q [RD_LATENCY];
  logic [DW-1:0]       dat_pipe_d [RD_LATENCY];
  logic [DW-1:0]       mem [1<<MEM_AW];

  logic                cmd_acc, beat_acc, is_wr, is_rd, bad_cmd;
  logic [MEM_AW-1:0]   idx, mem_widx;
  logic                mem_we, fifo_push, fifo_pop;
  logic [DW-1:0]       mem_wdata, fifo_head;
  logic [2:0]          fifo_cnt;
  logic                bp_cmd, bp_wdf;
  logic                unused_inputs;

  assign unused_inputs = ^{app_wdf_end, app_addr[ADDR_WIDTH-1:MEM_AW+3], app_addr[2:0]};

`ifdef DDR_RSP_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = (state_q == S_READY) ? lfsr_next(lfsr_q) : lfsr_q;
  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) lfsr_q <= LFSR_SEED;
    else             lfsr_q <= lfsr_d;
  end
  // Masks are taken from the value the LFSR holds in the cycle the ready applies to.
  assign bp_cmd = (lfsr_d[1:0] == 2'b00);
  assign bp_wdf = (lfsr_d[3:2] == 2'b00);
`else
  assign bp_cmd = 1'b0;
  assign bp_wdf = 1'b0;
`endif

  ddr_rsp_wdf_fifo #(.W(DW)) u_wdf_fifo (
    .ddr_ui_clk (ddr_ui_clk),
    .ddr_log_rst(ddr_log_rst),
    .push       (fifo_push),
    .push_data  (app_wdf_data),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_cnt)
  );

  always_comb begin
    cmd_acc  = app_en && app_rdy_q;
    beat_acc = app_wdf_wren && wdf_rdy_q;
    is_wr    = cmd_acc && (app_cmd == CMD_WRITE);
    is_rd    = cmd_acc && (app_cmd == CMD_READ);
    bad_cmd  = cmd_acc && !is_wr && !is_rd;
    idx      = app_addr[MEM_AW+2:3];

    mem_we     = 1'b0;
    mem_widx   = idx;
    mem_wdata  = app_wdf_data;
    fifo_push  = beat_acc;
    fifo_pop   = 1'b0;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;

    // A pending write implies an empty FIFO, so its beat bypasses the FIFO.
    if (pend_q && beat_acc) begin
      mem_we    = 1'b1;
      mem_widx  = pend_idx_q;
      fifo_push = 1'b0;
      pend_d    = 1'b0;
    end else if (is_wr) begin
      if (fifo_cnt != 3'd0) begin
        mem_we    = 1'b1;
        mem_wdata = fifo_head;
        fifo_pop  = 1'b1;
      end else if (beat_acc) begin
        mem_we    = 1'b1;
        fifo_push = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_idx_d = idx;
      end
    end

    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    calib_d     = calib_q;
    if (state_q == S_CALIB) begin
      if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) begin
        state_d = S_READY;
        calib_d = 1'b1;
      end else begin
        calib_cnt_d = calib_cnt_q + CW'(1);
      end
    end

    app_rdy_d = (state_d == S_READY) && !pend_d && !bp_cmd;
    wdf_rdy_d = (state_d == S_READY) && !bp_wdf &&
                !((fifo_cnt >= 3'd3) || ((fifo_cnt == 3'd2) && beat_acc));

    wr_cnt_d = wr_cnt_q + {31'd0, mem_we};
    rd_cnt_d = rd_cnt_q + {31'd0, vld_pipe_q[RD_LATENCY-1]};
    err_d    = err_q | bad_cmd;

    // Read data is captured at accept so later writes cannot leak into it.
    vld_pipe_d    = {vld_pipe_q[RD_LATENCY-2:0], is_rd};
    dat_pipe_d[0] = mem[idx];
    for (int i = 1; i < RD_LATENCY; i++) dat_pipe_d[i] = dat_pipe_q[i-1];
  end

  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) begin
      state_q     <= S_CALIB;
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
      app_rdy_q   <= 1'b0;
      wdf_rdy_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
      calib_q     <= calib_d;
      app_rdy_q   <= app_rdy_d;
      wdf_rdy_q   <= wdf_rdy_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_q       <= err_d;
      vld_pipe_q  <= vld_pipe_d;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe_q[i] <= dat_pipe_d[i];
    end
  end

  // Backing store deliberately survives reset.
  always_ff @(posedge ddr_ui_clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = wdf_rdy_q;
  assign init_calib_complete = calib_q;
  assign app_rd_data_valid   = vld_pipe_q[RD_LATENCY-1];
  assign app_rd_data         = dat_pipe_q[RD_LATENCY-1];
  assign wr_cnt              = wr_cnt_q;
  assign rd_cnt              = rd_cnt_q;
  assign err_cmd             = err_q;

endmodule

// File: tb/tb_ddr_app_responder.sv
// Randomized bench for ddr_app_responder against a queue-based memory model.
module tb_ddr_app_responder;
  import ddr_rsp_pkg::*;

  localparam int DW = 512, AW = 28, MAW = 10, CAL = 200, LAT = 8;

  logic          ddr_ui_clk = 1'b0;
  logic          ddr_log_rst = 1'b1;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_wdf_wren, app_wdf_end;
  logic [DW-1:0] app_wdf_data, app_rd_data;
  logic          app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, err_cmd;
  logic [31:0]   wr_cnt, rd_cnt;

  always #5 ddr_ui_clk = ~ddr_ui_clk;

  ddr_app_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(AW), .MEM_AW(MAW),
                      .CALIB_CYCLES(CAL), .RD_LATENCY(LAT)) dut (
    .ddr_ui_clk(ddr_ui_clk), .ddr_log_rst(ddr_log_rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cmd(err_cmd)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: memory array, FIFO as a queue, reads as dated queue entries.
  typedef struct {int due; logic [DW-1:0] data; bit known;} rd_t;
  logic [DW-1:0] m_mem   [1<<MAW];
  bit            m_known [1<<MAW];
  logic [DW-1:0] m_fifo  [$];
  rd_t           m_rdq   [$];
  bit            m_pend, m_rdy, m_wdf_rdy, m_err;
  int            m_pidx, cyc;
  int unsigned   m_wr, m_rd;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[MAW+2:3] = MAW'($urandom_range(0, 31));
    return a;
  endfunction

  task automatic commit(input int i, input logic [DW-1:0] d);
    m_mem[i] = d;
    m_known[i] = 1'b1;
    m_wr++;
  endtask

  task automatic check_outputs();
    bit exp_v;
    chk("calib", init_calib_complete, cyc >= CAL);
    chk("app_rdy", app_rdy, m_rdy);
    chk("wdf_rdy", app_wdf_rdy, m_wdf_rdy);
    chk("wr_cnt", wr_cnt, m_wr);
    chk("rd_cnt", rd_cnt, m_rd);
    chk("err_cmd", err_cmd, m_err);
    exp_v = (m_rdq.size() > 0) && (m_rdq[0].due == cyc);
    chk("rd_valid", app_rd_data_valid, exp_v);
    if (exp_v) begin
      if (m_rdq[0].known) chk("rd_data", app_rd_data, m_rdq[0].data);
      void'(m_rdq.pop_front());
      m_rd++;
    end
  endtask

  task automatic model_step();
    int  sz, ix;
    bit  ca, ba;
    sz = m_fifo.size();
    ca = app_en && m_rdy;
    ba = app_wdf_wren && m_wdf_rdy;
    ix = int'((app_addr >> 3) % (1 << MAW));
    if (ca && app_cmd == CMD_READ) m_rdq.push_back('{cyc + LAT, m_mem[ix], m_known[ix]});
    if (ca && app_cmd != CMD_READ && app_cmd != CMD_WRITE) m_err = 1'b1;
    if (m_pend && ba) begin
      commit(m_pidx, app_wdf_data);
      m_pend = 1'b0;
    end else if (ca && app_cmd == CMD_WRITE) begin
      if (sz > 0) begin
        commit(ix, m_fifo.pop_front());
        if (ba) m_fifo.push_back(app_wdf_data);
      end else if (ba) commit(ix, app_wdf_data);
      else begin
        m_pend = 1'b1;
        m_pidx = ix;
      end
    end else if (ba) m_fifo.push_back(app_wdf_data);
    m_rdy     = (cyc + 1 >= CAL) && !m_pend;
    m_wdf_rdy = (cyc + 1 >= CAL) && !(sz >= 3 || (sz == 2 && ba));
    cyc++;
  endtask

  // One clock: check at negedge, drive, advance the model at the posedge.
  task automatic step(input bit en, input logic [2:0] cmd, input logic [AW-1:0] addr,
                      input bit wren, input logic [DW-1:0] data);
    check_outputs();
    app_en = en; app_cmd = cmd; app_addr = addr;
    app_wdf_wren = wren; app_wdf_data = data; app_wdf_end = wren;
    @(posedge ddr_ui_clk);
    model_step();
    @(negedge ddr_ui_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, CMD_WRITE, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    ddr_log_rst = 1'b1;
    app_en = 1'b0; app_cmd = CMD_WRITE; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_data = '0; app_wdf_end = 1'b0;
    repeat (3) @(negedge ddr_ui_clk);
    m_fifo.delete(); m_rdq.delete();
    m_pend = 1'b0; m_rdy = 1'b0; m_wdf_rdy = 1'b0; m_err = 1'b0;
    m_wr = 0; m_rd = 0; cyc = 0;
    ddr_log_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_rd_data", app_rd_data, '0);

    // Commands during calibration must be ignored.
    for (int i = 0; i < CAL - 1; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), rnd_addr(),
           1'($urandom_range(0, 1)), rnd_data());
    idle(4);

    // Simple write then read back.
    step(1'b1, CMD_WRITE, 28'h10, 1'b1, {64{8'hA5}});
    step(1'b1, CMD_READ, 28'h10, 1'b0, '0);
    idle(LAT + 2);
    chk("a5_wr_cnt", wr_cnt, 32'd1);
    chk("a5_rd_cnt", rd_cnt, 32'd1);

    // Write command waiting on its data.
    step(1'b1, CMD_WRITE, 28'h20, 1'b0, '0);
    idle(5);
    step(1'b0, CMD_WRITE, '0, 1'b1, rnd_data());
    idle(2);

    // Data ahead of commands, then drain and read back.
    for (int k = 0; k < 5; k++) step(1'b0, CMD_WRITE, '0, 1'b1, rnd_data());
    for (int k = 0; k < 4; k++) step(1'b1, CMD_WRITE, AW'(28'h100 + 8*k), 1'b0, '0);
    idle(2);
    step(1'b0, CMD_WRITE, '0, 1'b1, rnd_data());
    for (int k = 0; k < 4; k++) step(1'b1, CMD_READ, AW'(28'h100 + 8*k), 1'b0, '0);
    idle(LAT + 2);

    // Address wrap and illegal command.
    step(1'b1, CMD_WRITE, AW'((1 << (MAW + 3)) + 8), 1'b1, rnd_data());
    step(1'b1, CMD_READ, 28'h8, 1'b0, '0);
    step(1'b1, 3'b111, 28'h40, 1'b0, '0);
    idle(LAT + 2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] c;
      r = $urandom_range(0, 99);
      c = (r < 45) ? CMD_WRITE : (r < 90) ? CMD_READ : 3'($urandom_range(2, 7));
      step(1'($urandom_range(0, 1)), c, rnd_addr(), 1'($urandom_range(0, 1)), rnd_data());
    end

    // Reset with reads in flight: nothing may emerge, memory survives.
    step(1'b0, CMD_WRITE, '0, 1'b1, rnd_data());
    idle(2);
    for (int k = 0; k < 3; k++) step(1'b1, CMD_READ, AW'(8*k), 1'b0, '0);
    do_reset();
    chk("rst2_calib", init_calib_complete, 1'b0);
    idle(CAL + 2);
    step(1'b1, CMD_READ, 28'h100, 1'b0, '0);
    step(1'b1, CMD_READ, 28'h8, 1'b0, '0);
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
